// File: rtl/vga_scanout.sv
// vga_scanout: translates pixel writes into 320x240x6 frame-buffer addresses and scans that buffer out as 640x480 VGA with 2x2 pixel doubling.
// Define VGA_SCANOUT_BOUNDS_EN to drop out-of-range writes and count them in drop_count.
module vga_scanout #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [8:0]  x_position,
    input  logic [7:0]  y_position,
    input  logic [5:0]  colour,
    input  logic        VGA_enable,
    output logic [16:0] fb_wr_addr,
    output logic [5:0]  fb_wr_data,
    output logic        fb_wr_en,
    output logic [16:0] fb_rd_addr,
    input  logic [5:0]  fb_rd_data,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic        VGA_CLK,
    output logic        frame_start,
    output logic [7:0]  drop_count
);

    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST     = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST     = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);

    logic        tick_q, tick_d;
    logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [16:0] rd_addr_q, rd_addr_d;
    logic        hs1_q, hs1_d, vs1_q, vs1_d, vis1_q, vis1_d;
    logic        hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
    logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
    logic [16:0] wr_addr_q, wr_addr_d;
    logic [5:0]  wr_data_q, wr_data_d;
    logic        wr_en_q, wr_en_d;
    logic [7:0]  drop_q, drop_d;

    logic        visible;
    logic [16:0] vy, hx, rd_addr_calc, wy, wr_addr_calc;
    logic        wr_ok;

    always_comb begin
        tick_d  = ~tick_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (tick_q) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end

        // Each frame-buffer pixel covers a 2x2 block of raster pixels; 320 = 256 + 64.
        visible      = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        vy           = {8'b0, v_cnt_q[9:1]};
        hx           = {8'b0, h_cnt_q[9:1]};
        rd_addr_calc = (vy << 8) + (vy << 6) + hx;

        rd_addr_d = rd_addr_q;
        hs1_d     = hs1_q;
        vs1_d     = vs1_q;
        vis1_d    = vis1_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        if (tick_q) begin
            rd_addr_d = visible ? rd_addr_calc : '0;
            hs1_d     = !((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END));
            vs1_d     = !((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END));
            vis1_d    = visible;
            // RAM data for the stage-1 address has landed by now, so syncs and colour leave together.
            hs_d      = hs1_q;
            vs_d      = vs1_q;
            blank_n_d = vis1_q;
            r_d       = vis1_q ? {4{fb_rd_data[5:4]}} : 8'h00;
            g_d       = vis1_q ? {4{fb_rd_data[3:2]}} : 8'h00;
            b_d       = vis1_q ? {4{fb_rd_data[1:0]}} : 8'h00;
        end
    end

    always_comb begin
        wy           = {9'b0, y_position};
        wr_addr_calc = (wy << 8) + (wy << 6) + {8'b0, x_position};
`ifdef VGA_SCANOUT_BOUNDS_EN
        wr_ok  = (x_position < 9'd320) && (y_position < 8'd240);
        drop_d = drop_q;
        if (VGA_enable && !wr_ok && (drop_q != 8'hFF))
            drop_d = drop_q + 8'd1;
`else
        wr_ok  = 1'b1;
        drop_d = '0;
`endif
        wr_en_d   = VGA_enable && wr_ok;
        wr_addr_d = VGA_enable ? wr_addr_calc : wr_addr_q;
        wr_data_d = VGA_enable ? colour : wr_data_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_q    <= 1'b0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            rd_addr_q <= '0;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
            vis1_q    <= 1'b0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            drop_q    <= '0;
        end else begin
            tick_q    <= tick_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            rd_addr_q <= rd_addr_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            vis1_q    <= vis1_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            drop_q    <= drop_d;
        end
    end

    assign fb_wr_addr  = wr_addr_q;
    assign fb_wr_data  = wr_data_q;
    assign fb_wr_en    = wr_en_q;
    assign fb_rd_addr  = rd_addr_q;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_CLK     = tick_q;
    assign frame_start = tick_q && (h_cnt_q == '0) && (v_cnt_q == '0);
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a shrunken raster (32x16 totals) with a behavioural dual-port frame buffer.
module tb_vga_scanout;

    localparam int HV = 16, HFP = 4, HSY = 8, HBP = 4;
    localparam int VV = 8, VFP = 2, VSY = 2, VBP = 4;
    localparam int HT = HV + HFP + HSY + HBP;
    localparam int VT = VV + VFP + VSY + VBP;
    localparam int FRAME = HT * VT * 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  x_position;
    logic [7:0]  y_position;
    logic [5:0]  colour;
    logic        VGA_enable;
    logic [16:0] fb_wr_addr, fb_rd_addr;
    logic [5:0]  fb_wr_data, rd_q;
    logic        fb_wr_en;
    logic [7:0]  VGA_R, VGA_G, VGA_B, drop_count;
    logic        VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, frame_start;

    vga_scanout #(
        .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
    ) dut (
        .clock(clk), .reset(rst),
        .x_position(x_position), .y_position(y_position), .colour(colour), .VGA_enable(VGA_enable),
        .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data), .fb_wr_en(fb_wr_en),
        .fb_rd_addr(fb_rd_addr), .fb_rd_data(rd_q),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
        .VGA_CLK(VGA_CLK), .frame_start(frame_start), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Frame buffer: read-old-data on collision, 1-clock read latency.
    logic [5:0] mem [0:131071];
    initial for (int a = 0; a < 131072; a++) mem[a] = 6'(a) ^ 6'(a >> 6) ^ 6'(a >> 12);
    always @(posedge clk) begin
        rd_q <= mem[fb_rd_addr];
        if (fb_wr_en) mem[fb_wr_addr] = fb_wr_data;
    end

    typedef struct packed {
        logic        en;
        logic [16:0] addr;
        logic [5:0]  data;
    } wr_t;

    wr_t         wq[$];
    logic [26:0] pq[$];
    int          vectors = 0;
    int          errors  = 0;
    int          exp_drop = 0;
    int          k;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_clk"}, 32'(VGA_CLK), 0);
        chk({tag, "_hs_vs"}, {VGA_HS, VGA_VS}, 2'b11);
        chk({tag, "_blank"}, 32'(VGA_BLANK_N), 0);
        chk({tag, "_rgb"}, {VGA_R, VGA_G, VGA_B}, 0);
        chk({tag, "_wr"}, {fb_wr_en, fb_wr_addr, fb_wr_data}, 0);
        chk({tag, "_rd_addr"}, 32'(fb_rd_addr), 0);
        chk({tag, "_fs"}, 32'(frame_start), 0);
        chk({tag, "_drop"}, 32'(drop_count), 0);
        chk({tag, "_sync_n"}, 32'(VGA_SYNC_N), 0);
    endtask

    task automatic do_wr(input int x, input int y, input logic [5:0] c, input logic en);
        wr_t e;
        logic ok;
        x_position = 9'(x);
        y_position = 8'(y);
        colour     = c;
        VGA_enable = en;
        ok = en;
`ifdef VGA_SCANOUT_BOUNDS_EN
        if (en && (x >= 320 || y >= 240)) begin
            ok = 1'b0;
            if (exp_drop < 255) exp_drop++;
        end
`endif
        e.en   = ok;
        e.addr = 17'(y * 320 + x);
        e.data = c;
        wq.push_back(e);
        @(negedge clk);
        e = wq.pop_front();
        chk("wr_en", 32'(fb_wr_en), 32'(e.en));
        if (e.en) begin
            chk("wr_addr", 32'(fb_wr_addr), 32'(e.addr));
            chk("wr_data", 32'(fb_wr_data), 32'(e.data));
        end
        chk("drop_count", 32'(drop_count), 32'(exp_drop));
    endtask

    function automatic logic [7:0] ex(input logic [1:0] c);
        return {c, c, c, c};
    endfunction

    task automatic run_disp(input int ncyc);
        int cnt, hh, vv, c, fs_seen, fs_first, fs_second, hs_low, vs_low;
        logic vis, hs, vs;
        logic [5:0] d;
        logic [26:0] px;
        fs_seen = 0; fs_first = -1; fs_second = -1; hs_low = 0; vs_low = 0;
        for (k = 0; k < ncyc; k++) begin
            cnt = k / 2;
            hh  = cnt % HT;
            vv  = (cnt / HT) % VT;
            chk("vga_clk", 32'(VGA_CLK), 32'(k % 2));
            chk("frame_start", 32'(frame_start), 32'((k % 2 == 1) && (cnt % (HT * VT) == 0)));
            if (frame_start) begin
                if (fs_seen == 0) fs_first = k;
                if (fs_seen == 1) fs_second = k;
                fs_seen++;
            end
            if (k == 1) chk("fs_after_reset", 32'(frame_start), 1);
            if (k % 2 == 1) begin
                vis = (hh < HV) && (vv < VV);
                hs  = !((hh >= HV + HFP) && (hh < HV + HFP + HSY));
                vs  = !((vv >= VV + VFP) && (vv < VV + VFP + VSY));
                d   = mem[(vv / 2) * 320 + (hh / 2)];
                pq.push_back({hs, vs, vis, vis ? ex(d[5:4]) : 8'h00,
                              vis ? ex(d[3:2]) : 8'h00, vis ? ex(d[1:0]) : 8'h00});
            end
            if (k >= 2 && k % 2 == 0) begin
                c  = k / 2 - 1;
                hh = c % HT;
                vv = (c / HT) % VT;
                chk("rd_addr", 32'(fb_rd_addr),
                    (hh < HV && vv < VV) ? 32'((vv / 2) * 320 + hh / 2) : 0);
                if (vv == 2 && hh < 4) chk("rd_addr_v2", 32'(fb_rd_addr), 32'(320 + hh / 2));
            end
            if (k >= 4 && k % 2 == 0) begin
                px = pq.pop_front();
                chk("pixel", {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B}, 32'(px));
            end
            if (k == 4 || k == 6 || k == 2 * HT + 4) begin
                chk("px00_rgb", {VGA_R, VGA_G, VGA_B}, 24'hFF5500);
                chk("px00_blank", 32'(VGA_BLANK_N), 1);
            end
            if (k == 2 * HV + 4 || k == 2 * (HT - 1) + 4) begin
                chk("hblank_rgb", {VGA_R, VGA_G, VGA_B}, 0);
                chk("hblank_blank", 32'(VGA_BLANK_N), 0);
            end
            if (k >= 4 && k < 4 + FRAME) begin
                if (!VGA_HS) hs_low++;
                if (!VGA_VS) vs_low++;
            end
            @(negedge clk);
        end
        chk("fs_count", 32'(fs_seen), 2);
        chk("fs_period", 32'(fs_second - fs_first), 32'(FRAME));
        chk("hs_low_clocks", 32'(hs_low), 32'(VT * 2 * HSY));
        chk("vs_low_clocks", 32'(vs_low), 32'(2 * HT * VSY));
    endtask

    initial begin
        rst = 1'b0;
        x_position = '0; y_position = '0; colour = '0; VGA_enable = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_rst("por");
        rst = 1'b0;

        do_wr(319, 239, 6'b110100, 1'b1);
        do_wr(0, 0, 6'b110100, 1'b1);
        do_wr(5, 1, 6'h2A, 1'b1);
        do_wr(7, 3, 6'h15, 1'b1);
        do_wr(320, 0, 6'h3F, 1'b1);
        do_wr(1, 1, 6'h00, 1'b0);
        do_wr(400, 250, 6'h11, 1'b1);
`ifdef VGA_SCANOUT_BOUNDS_EN
        for (int i = 0; i < 260; i++) do_wr(i % 2 ? 330 : 10, i % 2 ? 5 : 245, 6'h01, 1'b1);
        chk("drop_saturated", 32'(drop_count), 255);
`endif
        VGA_enable = 1'b0;
        repeat (300) @(negedge clk);

        // Reset mid-frame with a write in flight.
        x_position = 9'd3; y_position = 8'd3; VGA_enable = 1'b1;
        @(negedge clk);
        chk("pre_reset_wr_en", 32'(fb_wr_en), 1);
        VGA_enable = 1'b0;
        rst = 1'b1;
        #1;
        exp_drop = 0;
        chk_rst("mid");
        @(negedge clk);
        rst = 1'b0;

        run_disp(2 * FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
